// File: rtl/alu_control_unit.sv
// -----------------------------------------------------------------------------
// alu_control_unit
//   Sequencer that sits in front of the 4-bit ALU. Fetches 8-bit instructions
//   from program ROM and decodes them. It holds a 4x4-bit register file, feeds
//   the ALU operands, opcode and enable, and writes the ALU result and flags
//   back. One instruction executes at a time through a multi-cycle FSM:
//   IDLE, FETCH, DECODE, OPERAND, EXEC, WB, HALT (plus STALL when single-step
//   is built in).
//
//   Instruction byte: [7:4] opcode, [3:2] rd, [1:0] rs.
//   LDI/JMP/JZ/JC take a second byte at PC+1.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   start       in   leave IDLE and begin execution (looked at in IDLE only)
//   step        in   single-step advance (only with CU_SINGLE_STEP_EN)
//   instr_addr  out  program-memory address, equal to the PC
//   instr_data  in   program-memory data, combinational read of instr_addr
//   alu_a       out  ALU operand A = R[rd] (registered, held outside EXEC)
//   alu_b       out  ALU operand B = R[rs] (registered, held outside EXEC)
//   alu_opcode  out  ALU opcode 1000..1111 (registered, held outside EXEC)
//   alu_en      out  high only during EXEC of an ALU instruction
//   alu_result  in   ALU result
//   alu_z/n/c/v in   ALU zero / negative / carry / overflow
//   flags       out  latched {Z,N,C,V}; updated only in WB of an ALU op
//   busy        out  high in every state except IDLE, HALT and STALL
//   halted      out  high in HALT
//
// Build option
//   CU_SINGLE_STEP_EN: adds the step port. Every transition that would enter
//   FETCH waits in STALL (busy low) until a rising edge on step. Each rising
//   edge runs exactly one instruction.
// -----------------------------------------------------------------------------
module alu_control_unit #(
  // ADDR_W must not exceed 8, because jump targets come from the operand byte
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef CU_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [7:0]        instr_data,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [3:0]        alu_opcode,
  output logic              alu_en,
  input  logic [3:0]        alu_result,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic [3:0]        flags,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    OPERAND,
    EXEC,
    WB,
    HALT,
    STALL
  } state_t;

  localparam logic [3:0] OP_LDI = 4'b0001;
  localparam logic [3:0] OP_MOV = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JZ  = 4'b0100;
  localparam logic [3:0] OP_JC  = 4'b0101;
  localparam logic [3:0] OP_HLT = 4'b0111;

  state_t            state_q, state_d, fetchNext;
  logic [ADDR_W-1:0] pc_q, pc_d, pcInc, target;
  logic [7:0]        ir_q, ir_d;
  logic [3:0]        regs_q [4];
  logic [3:0]        flags_q, flags_d;
  logic [3:0]        aluA_q, aluA_d;
  logic [3:0]        aluB_q, aluB_d;
  logic [3:0]        aluOp_q, aluOp_d;
  logic              aluEn_q, aluEn_d;
  logic [3:0]        res_q, res_d;
  logic [3:0]        capFlags_q, capFlags_d;
  logic              busy_q, halted_q;
  logic              regWe;
  logic [1:0]        regWa;
  logic [3:0]        regWd;
  logic [1:0]        rd, rs;

  assign rd     = ir_q[3:2];
  assign rs     = ir_q[1:0];
  assign pcInc  = pc_q + 1'b1;
  assign target = instr_data[ADDR_W-1:0];

`ifdef CU_SINGLE_STEP_EN
  logic stepPrev_q, stepPend_q, stepPend_d, stepGo;

  // A rising edge on step is remembered until a transition into FETCH uses it.
  // Then a pulse that arrives in the middle of an instruction still releases
  // the next instruction. Pending pulses are dropped in IDLE and HALT, so
  // start is still needed before anything is fetched.
  assign stepGo     = stepPend_q | (step & ~stepPrev_q);
  assign fetchNext  = stepGo ? FETCH : STALL;
  assign stepPend_d = stepGo && (state_d != FETCH) &&
                      (state_q != IDLE) && (state_q != HALT);

  // Step edge detector and pending-pulse flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stepPrev_q <= 1'b0;
      stepPend_q <= 1'b0;
    end else begin
      stepPrev_q <= step;
      stepPend_q <= stepPend_d;
    end
  end
`else
  assign fetchNext = FETCH;
`endif

  // Next-state and datapath decode. Each state either moves the PC, loads the
  // IR, stages ALU operands, or produces at most one register-file write. That
  // write comes from MOV in DECODE, LDI in OPERAND, or the ALU result in WB,
  // so only one write port is needed. Taken jumps override the PC increment.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    flags_d    = flags_q;
    aluA_d     = aluA_q;
    aluB_d     = aluB_q;
    aluOp_d    = aluOp_q;
    aluEn_d    = 1'b0;
    res_d      = res_q;
    capFlags_d = capFlags_q;
    regWe      = 1'b0;
    regWa      = rd;
    regWd      = 4'd0;
    case (state_q)
      IDLE: begin
        if (start) state_d = fetchNext;
      end
      FETCH: begin
        ir_d    = instr_data;
        pc_d    = pcInc;
        state_d = DECODE;
      end
      DECODE: begin
        if (ir_q[7]) begin
          aluA_d  = regs_q[rd];
          aluB_d  = regs_q[rs];
          aluOp_d = ir_q[7:4];
          aluEn_d = 1'b1;
          state_d = EXEC;
        end else begin
          case (ir_q[7:4])
            OP_LDI, OP_JMP, OP_JZ, OP_JC: state_d = OPERAND;
            OP_MOV: begin
              regWe   = 1'b1;
              regWd   = regs_q[rs];
              state_d = fetchNext;
            end
            OP_HLT:  state_d = HALT;
            default: state_d = fetchNext;
          endcase
        end
      end
      OPERAND: begin
        pc_d = pcInc;
        case (ir_q[7:4])
          OP_LDI: begin
            regWe = 1'b1;
            regWd = instr_data[3:0];
          end
          OP_JMP: pc_d = target;
          OP_JZ:  if (flags_q[3]) pc_d = target;
          OP_JC:  if (flags_q[1]) pc_d = target;
          default: ;
        endcase
        state_d = fetchNext;
      end
      EXEC: begin
        res_d      = alu_result;
        capFlags_d = {alu_z, alu_n, alu_c, alu_v};
        state_d    = WB;
      end
      WB: begin
        regWe   = 1'b1;
        regWd   = res_q;
        flags_d = capFlags_q;
        state_d = fetchNext;
      end
      HALT:    state_d = HALT;
      STALL:   state_d = fetchNext;
      default: state_d = IDLE;
    endcase
  end

  // All FSM state, the register file and the registered outputs. busy and
  // halted are computed from the next state, so they change on the same edge
  // as the state and come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ir_q       <= 8'd0;
      flags_q    <= 4'd0;
      aluA_q     <= 4'd0;
      aluB_q     <= 4'd0;
      aluOp_q    <= 4'd0;
      aluEn_q    <= 1'b0;
      res_q      <= 4'd0;
      capFlags_q <= 4'd0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= 4'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      flags_q    <= flags_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      aluOp_q    <= aluOp_d;
      aluEn_q    <= aluEn_d;
      res_q      <= res_d;
      capFlags_q <= capFlags_d;
      busy_q     <= (state_d != IDLE) && (state_d != HALT) && (state_d != STALL);
      halted_q   <= (state_d == HALT);
      if (regWe) regs_q[regWa] <= regWd;
    end
  end

  assign instr_addr = pc_q;
  assign alu_a      = aluA_q;
  assign alu_b      = aluB_q;
  assign alu_opcode = aluOp_q;
  assign alu_en     = aluEn_q;
  assign flags      = flags_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule
